// File: rtl/wb_result_scheduler.sv
// Result/writeback bus scheduler: three one-entry holding registers (ALU, LS, MUL)
// share one CDB using fixed priority with aging. Optional same-cycle bypass: WB_RESULT_BYPASS_EN.

module wb_result_slot #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    input  logic              bypass,
    output logic              hold_v,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data,
    output logic              starved,
    output logic              stall
);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age;
    logic             load;

    assign stall   = hold_v && !grant && !flush;
    assign starved = hold_v && (age >= AGE_MAX);
    // A bypassed result goes straight to the bus and must not be stored too.
    assign load    = in_valid && !stall && !bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v <= 1'b0;
            tag    <= '0;
            data   <= '0;
            age    <= '0;
        end else if (flush) begin
            hold_v <= 1'b0;
            age    <= '0;
        end else if (load) begin
            hold_v <= 1'b1;
            tag    <= in_tag;
            data   <= in_data;
            age    <= '0;
        end else if (grant) begin
            hold_v <= 1'b0;
            age    <= '0;
        end else if (hold_v && age != AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end
endmodule

module wb_result_scheduler #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ls_valid,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [DATA_W-1:0] ls_data,
    input  logic              mul_valid,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        sel_result,
    output logic              stall_alu,
    output logic              stall_ls,
    output logic              stall_mul
);
    localparam int NUM_SRC = 3;

    logic [NUM_SRC-1:0]             in_valid;
    logic [NUM_SRC-1:0][TAG_W-1:0]  in_tag;
    logic [NUM_SRC-1:0][DATA_W-1:0] in_data;
    logic [NUM_SRC-1:0]             hold_v, starved, stall, grant, bypass, pick;
    logic [NUM_SRC-1:0][TAG_W-1:0]  hold_tag;
    logic [NUM_SRC-1:0][DATA_W-1:0] hold_data;
    logic [1:0]                     win;
    logic                           win_any;

    assign in_valid = {mul_valid, ls_valid, alu_valid};
    assign in_tag   = {mul_tag, ls_tag, alu_tag};
    assign in_data  = {mul_data, ls_data, alu_data};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        wb_result_slot #(
            .DATA_W      (DATA_W),
            .TAG_W       (TAG_W),
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .in_valid(in_valid[i]),
            .in_tag  (in_tag[i]),
            .in_data (in_data[i]),
            .grant   (grant[i]),
            .bypass  (bypass[i]),
            .hold_v  (hold_v[i]),
            .tag     (hold_tag[i]),
            .data    (hold_data[i]),
            .starved (starved[i]),
            .stall   (stall[i])
        );
    end

    assign stall_alu = stall[0];
    assign stall_ls  = stall[1];
    assign stall_mul = stall[2];

    // Starved sources pre-empt fixed priority; index 0 (ALU) wins ties.
    assign pick = (|starved) ? starved : hold_v;

    always_comb begin
        win     = 2'd3;
        win_any = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win     = 2'(i);
                win_any = 1'b1;
            end
        end
    end

    assign grant = (win_any && !flush) ? (NUM_SRC'(1) << win) : '0;

`ifdef WB_RESULT_BYPASS_EN
    logic [1:0] byp_win;
    logic       byp_any;
    logic       byp_en;

    // Bypass only when nothing is held, so it never competes with a stored result.
    assign byp_en = rst && !flush && !(|hold_v);

    always_comb begin
        byp_win = 2'd3;
        byp_any = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                byp_win = 2'(i);
                byp_any = 1'b1;
            end
        end
    end

    assign bypass = (byp_en && byp_any) ? (NUM_SRC'(1) << byp_win) : '0;

    always_comb begin
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        sel_result = 2'd3;
        if (win_any && !flush) begin
            cdb_valid  = 1'b1;
            cdb_tag    = hold_tag[win];
            cdb_data   = hold_data[win];
            sel_result = win;
        end else if (byp_en && byp_any) begin
            cdb_valid  = 1'b1;
            cdb_tag    = in_tag[byp_win];
            cdb_data   = in_data[byp_win];
            sel_result = byp_win;
        end
    end
`else
    assign bypass = '0;

    always_comb begin
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        sel_result = 2'd3;
        if (win_any && !flush) begin
            cdb_valid  = 1'b1;
            cdb_tag    = hold_tag[win];
            cdb_data   = hold_data[win];
            sel_result = win;
        end
    end
`endif
endmodule

// File: tb/tb_wb_result_scheduler.sv
// Directed bench for wb_result_scheduler: reset, single result, collision,
// aging, flush, mid-transfer reset and bypass/latency behaviour.

module tb_wb_result_scheduler;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              alu_valid = 1'b0, ls_valid = 1'b0, mul_valid = 1'b0;
    logic [TAG_W-1:0]  alu_tag = '0, ls_tag = '0, mul_tag = '0;
    logic [DATA_W-1:0] alu_data = '0, ls_data = '0, mul_data = '0;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        sel_result;
    logic              stall_alu, stall_ls, stall_mul;

    int checks = 0;
    int failures = 0;

    wb_result_scheduler #(.DATA_W(DATA_W), .TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data),
        .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_data(ls_data),
        .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .sel_result(sel_result),
        .stall_alu(stall_alu), .stall_ls(stall_ls), .stall_mul(stall_mul)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_valid = 1'b0;
        ls_valid  = 1'b0;
        mul_valid = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_vld"}, 64'(cdb_valid), 64'd0);
        chk({name, "_sel"}, 64'(sel_result), 64'd3);
        chk({name, "_stl"}, 64'({stall_alu, stall_ls, stall_mul}), 64'd0);
        chk({name, "_tag"}, 64'(cdb_tag), 64'd0);
    endtask

    initial begin
        // Reset held with toggling inputs.
        for (int i = 0; i < 4; i++) begin
            alu_valid = i[0]; ls_valid = ~i[0]; mul_valid = i[1];
            alu_tag = 6'(i + 1); ls_tag = 6'(i + 2); mul_tag = 6'(i + 3);
            #1;
            chk_idle("rst");
            tick();
        end
        idle_in();
        rst = 1'b1;
        tick();
        chk_idle("post_rst");

        // Single ALU result.
        alu_valid = 1'b1; alu_tag = 6'd5; alu_data = 32'hA5;
        #1;
        chk("single_stall_in", 64'(stall_alu), 64'd0);
        tick();
        idle_in();
        #1;
        chk("single_vld", 64'(cdb_valid), 64'd1);
        chk("single_tag", 64'(cdb_tag), 64'd5);
        chk("single_data", 64'(cdb_data), 64'hA5);
        chk("single_sel", 64'(sel_result), 64'd0);
        chk("single_stall", 64'(stall_alu), 64'd0);
        tick();
        chk_idle("single_after");

        // Three-way collision.
        alu_valid = 1'b1; alu_tag = 6'd1; alu_data = 32'h11;
        ls_valid  = 1'b1; ls_tag  = 6'd2; ls_data  = 32'h22;
        mul_valid = 1'b1; mul_tag = 6'd3; mul_data = 32'h33;
        tick();
        idle_in();
        #1;
        chk("col1_tag", 64'(cdb_tag), 64'd1);
        chk("col1_sel", 64'(sel_result), 64'd0);
        chk("col1_stall_ls", 64'(stall_ls), 64'd1);
        chk("col1_stall_mul", 64'(stall_mul), 64'd1);
        tick();
        chk("col2_tag", 64'(cdb_tag), 64'd2);
        chk("col2_data", 64'(cdb_data), 64'h22);
        chk("col2_sel", 64'(sel_result), 64'd1);
        chk("col2_stall_mul", 64'(stall_mul), 64'd1);
        tick();
        chk("col3_tag", 64'(cdb_tag), 64'd3);
        chk("col3_sel", 64'(sel_result), 64'd2);
        chk("col3_stall_mul", 64'(stall_mul), 64'd0);
        tick();
        chk_idle("col_after");

        // Aging: MUL once, ALU every cycle with fresh tags.
        mul_valid = 1'b1; mul_tag = 6'd9; mul_data = 32'h99;
        alu_valid = 1'b1; alu_tag = 6'd10; alu_data = 32'h100;
        tick();
        mul_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            alu_tag = 6'(10 + k); alu_data = 32'(256 + k);
            #1;
            chk("age_alu_sel", 64'(sel_result), 64'd0);
            chk("age_alu_tag", 64'(cdb_tag), 64'(10 + k - 1));
            chk("age_mul_stall", 64'(stall_mul), 64'd1);
            tick();
        end
        alu_tag = 6'd15; alu_data = 32'h10F;
        #1;
        chk("age_mul_sel", 64'(sel_result), 64'd2);
        chk("age_mul_tag", 64'(cdb_tag), 64'd9);
        chk("age_mul_data", 64'(cdb_data), 64'h99);
        chk("age_alu_stall", 64'(stall_alu), 64'd1);
        tick();
        chk("age_alu_back_sel", 64'(sel_result), 64'd0);
        chk("age_alu_back_tag", 64'(cdb_tag), 64'd14);
        chk("age_alu_back_stall", 64'(stall_alu), 64'd0);
        tick();
        idle_in();
        #1;
        chk("age_alu_last_tag", 64'(cdb_tag), 64'd15);
        tick();
        chk_idle("age_after");

        // Flush with all three registers occupied.
        alu_valid = 1'b1; alu_tag = 6'd20;
        ls_valid  = 1'b1; ls_tag  = 6'd21;
        mul_valid = 1'b1; mul_tag = 6'd22;
        tick();
        flush = 1'b1;
        alu_tag = 6'd30; ls_tag = 6'd31; mul_tag = 6'd32;
        #1;
        chk_idle("flush_cyc");
        tick();
        flush = 1'b0;
        idle_in();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_idle("flush_after");
            tick();
        end

        // Reset mid-transfer.
        alu_valid = 1'b1; alu_tag = 6'd40;
        ls_valid  = 1'b1; ls_tag  = 6'd41;
        tick();
        idle_in();
        #1;
        chk("mrst_pre_tag", 64'(cdb_tag), 64'd40);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("mrst");
        tick();
        rst = 1'b1;
        tick();
        chk_idle("mrst_after");

        // LS from empty: bypass same cycle, otherwise one cycle later.
        ls_valid = 1'b1; ls_tag = 6'd7; ls_data = 32'h77;
`ifdef WB_RESULT_BYPASS_EN
        #1;
        chk("byp_vld", 64'(cdb_valid), 64'd1);
        chk("byp_tag", 64'(cdb_tag), 64'd7);
        chk("byp_sel", 64'(sel_result), 64'd1);
        tick();
        idle_in();
        #1;
        chk_idle("byp_after");
`else
        #1;
        chk("nobyp_same", 64'(cdb_valid), 64'd0);
        tick();
        idle_in();
        #1;
        chk("nobyp_tag", 64'(cdb_tag), 64'd7);
        chk("nobyp_sel", 64'(sel_result), 64'd1);
        tick();
        chk_idle("nobyp_after");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
